reorder_buffer: RTL and testbench

- Circular in-order tracking buffer for the out-of-order core.
- Hands a tag to each newly issued instruction and triggers the reservation-station load for it.
- Captures results from the ALU completion buses into the tagged entry.
- Exposes every entry's ready/data to the reservation stations for operand wake-up, and retires entries in program order to the regfile.

---
 rtl/reorder_buffer_pkg.sv | 45 ++++
 rtl/reorder_buffer_rob_ptr.sv | 44 ++++
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 tb/tb_reorder_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer_pkg
//  Description : Shared types for the reorder buffer: stored entry, result
//                bus record and the per-entry broadcast view.
//  Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int DATA_W    = 32;
    localparam int RD_W      = 5;
    // Widest tag any instance may use; bus tags are zero-extended to this.
    localparam int MAX_TAG_W = 8;

    // One tracked instruction.
    typedef struct packed {
        logic              valid;
        logic              rdy;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // One ALU completion bus.
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    data;
    } cdb_t;

    // What the reservation stations see for an entry, indexed by tag.
    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] data;
    } rob_t;

    // A result is only visible as present while its entry is live.
    function automatic rob_t to_rob_view(input rob_entry_t e);
        rob_t v;
        v.rdy  = e.valid & e.rdy;
        v.data = e.data;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_rob_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : rob_ptr
//  Description : Modulo-SIZE ring pointer with increment enable and
//                synchronous clear (clear wins over increment).
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr #(
    parameter int SIZE  = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,    // asynchronous, active-low
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear, or step with explicit wrap at SIZE-1.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PTR_W'(SIZE - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order tracking buffer. Grants tags at the tail,
//                captures ALU results by tag, broadcasts every entry to the
//                reservation stations and retires the head in program order.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,      // asynchronous, active-low
    input  logic                      flush,
    input  logic                      alloc_req,
    input  logic [4:0]                alloc_rd,
    output logic                      alloc_gnt,
    output logic [TAG_W-1:0]          alloc_tag,
    output logic                      load_rs,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*32-1:0]     cdb_data,
    output logic [SIZE-1:0]           rob_rdy,
    output logic [SIZE*32-1:0]        rob_data,
    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_data,
    output logic [TAG_W-1:0]          commit_tag,
    output logic [TAG_W:0]            num_available
);

    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    rob_entry_t       entries_q [SIZE];
    rob_entry_t       entries_d [SIZE];
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    cdb_t             cdb       [NUM_CDB];
    rob_t             rob_view  [SIZE];

    // Unpack the flat result buses into records.
    generate
        for (genvar i = 0; i < NUM_CDB; i++) begin : g_cdb
            assign cdb[i] = {cdb_valid[i],
                             MAX_TAG_W'(cdb_tag[i*TAG_W +: TAG_W]),
                             cdb_data[i*32 +: 32]};
        end
    endgenerate

    // Head and tail ring pointers; flush snaps both back to entry 0.
    rob_ptr #(.SIZE(SIZE), .PTR_W(PTR_W)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (commit_valid),
        .ptr (head)
    );

    rob_ptr #(.SIZE(SIZE), .PTR_W(PTR_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (alloc_gnt),
        .ptr (tail)
    );

    // Grant and retire decisions; rst high means out of reset, so both are
    // held off while reset is asserted. Full is judged on the registered
    // count, so a same-cycle retire never opens a slot early.
    always_comb begin
        alloc_gnt     = rst & alloc_req & (count_q < (PTR_W+1)'(SIZE)) & ~flush;
        load_rs       = alloc_gnt;
        alloc_tag     = TAG_W'(tail);
        commit_valid  = rst & entries_q[head].valid & entries_q[head].rdy & ~flush;
        commit_rd     = entries_q[head].rd;
        commit_data   = entries_q[head].data;
        commit_tag    = TAG_W'(head);
        num_available = (TAG_W+1)'(SIZE) - (TAG_W+1)'(count_q);
    end

    // Entry and occupancy update: flush clears everything; otherwise result
    // capture, then retire clear, then allocation write.
    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            entries_d[k] = entries_q[k];
        end
        count_d = count_q;
        if (flush) begin
            for (int k = 0; k < SIZE; k++) begin
                entries_d[k] = '0;
            end
            count_d = '0;
        end else begin
            // Highest bus applied first so the lowest index has the last word.
            for (int k = 0; k < SIZE; k++) begin
                for (int i = NUM_CDB - 1; i >= 0; i--) begin
                    if (cdb[i].valid && (cdb[i].tag == MAX_TAG_W'(k)) && entries_q[k].valid) begin
                        entries_d[k].rdy  = 1'b1;
                        entries_d[k].data = cdb[i].data;
                    end
                end
            end
            if (commit_valid) begin
                entries_d[head] = '0;
            end
            if (alloc_gnt) begin
                entries_d[tail] = '{valid: 1'b1, rdy: 1'b0, rd: alloc_rd, data: '0};
            end
            count_d = count_q + (PTR_W+1)'(alloc_gnt) - (PTR_W+1)'(commit_valid);
        end
    end

    // Entry storage and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SIZE; k++) begin
                entries_q[k] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                entries_q[k] <= entries_d[k];
            end
            count_q <= count_d;
        end
    end

    // Broadcast every entry straight from its register.
    generate
        for (genvar k = 0; k < SIZE; k++) begin : g_bcast
            assign rob_view[k]         = to_rob_view(entries_q[k]);
            assign rob_rdy[k]          = rob_view[k].rdy;
            assign rob_data[k*32 +: 32] = rob_view[k].data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Self-checking bench for reorder_buffer. A program-order
//                queue model predicts each cycle's outputs and retirements;
//                a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int SIZE    = 8;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         flush     = 1'b0;
    logic         alloc_req = 1'b0;
    logic [4:0]   alloc_rd  = '0;
    logic [1:0]   cdb_valid = '0;
    logic [7:0]   cdb_tag   = '0;
    logic [63:0]  cdb_data  = '0;
    logic         alloc_gnt;
    logic [3:0]   alloc_tag;
    logic         load_rs;
    logic [7:0]   rob_rdy;
    logic [255:0] rob_data;
    logic         commit_valid;
    logic [4:0]   commit_rd;
    logic [31:0]  commit_data;
    logic [3:0]   commit_tag;
    logic [4:0]   num_available;

    always #5 clk = ~clk;

    reorder_buffer #(.SIZE(SIZE), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_req     (alloc_req),
        .alloc_rd      (alloc_rd),
        .alloc_gnt     (alloc_gnt),
        .alloc_tag     (alloc_tag),
        .load_rs       (load_rs),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .rob_rdy       (rob_rdy),
        .rob_data      (rob_data),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_data   (commit_data),
        .commit_tag    (commit_tag),
        .num_available (num_available)
    );

    typedef struct { int tag; logic [4:0] rd; bit rdy; logic [31:0] data; } m_ent_t;
    typedef struct { bit gnt; logic [3:0] tag; bit cv; logic [4:0] navail;
                     logic [7:0] rdy; logic [255:0] data; } exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; logic [3:0] tag; } cmt_t;

    m_ent_t mq[$];        // live instructions, oldest first
    int     ntag   = 0;   // tag the next allocation receives
    exp_t   exp_q[$];
    cmt_t   cq[$];
    int     errors = 0;
    int     checks = 0;
    exp_t   mon_e;
    cmt_t   mon_c;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of stimulus: drive, predict, then advance the model.
    task automatic step(input bit req, input logic [4:0] rd, input bit fl, input logic [1:0] cv,
                        input logic [3:0] t0, input logic [3:0] t1,
                        input logic [31:0] d0, input logic [31:0] d1);
        exp_t        e;
        cmt_t        c;
        bit          do_commit;
        logic [3:0]  tg;
        logic [31:0] dv;
        alloc_req = req; alloc_rd = rd; flush = fl;
        cdb_valid = cv; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
        if (!rst) begin
            mq.delete();
            ntag = 0;
        end
        e.gnt     = rst && !fl && req && (mq.size() < SIZE);
        e.tag     = 4'(ntag);
        do_commit = rst && !fl && (mq.size() > 0) && mq[0].rdy;
        e.cv      = do_commit;
        e.navail  = 5'(SIZE - mq.size());
        e.rdy     = '0;
        e.data    = '0;
        foreach (mq[j]) begin
            if (mq[j].rdy) begin
                e.rdy[mq[j].tag]           = 1'b1;
                e.data[mq[j].tag*32 +: 32] = mq[j].data;
            end
        end
        exp_q.push_back(e);
        if (do_commit) begin
            c.rd = mq[0].rd; c.data = mq[0].data; c.tag = 4'(mq[0].tag);
            cq.push_back(c);
        end
        if (!rst || fl) begin
            mq.delete();
            ntag = 0;
        end else begin
            for (int b = NUM_CDB - 1; b >= 0; b--) begin
                if (cv[b]) begin
                    tg = (b == 0) ? t0 : t1;
                    dv = (b == 0) ? d0 : d1;
                    foreach (mq[j]) begin
                        if (mq[j].tag == int'(tg)) begin
                            mq[j].rdy  = 1'b1;
                            mq[j].data = dv;
                        end
                    end
                end
            end
            if (do_commit) void'(mq.pop_front());
            if (e.gnt) begin
                mq.push_back('{tag: ntag, rd: rd, rdy: 1'b0, data: 32'h0});
                ntag = (ntag + 1) % SIZE;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    task automatic alloc(input logic [4:0] rd);
        step(1'b1, rd, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] t, input logic [31:0] d);
        step(1'b0, 5'd0, 1'b0, 2'b01, t, 4'd0, d, 32'h0);
    endtask

    task automatic do_flush();
        step(1'b0, 5'd0, 1'b1, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    // Monitor: compare every presented cycle and every retirement.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("alloc_gnt", 256'(alloc_gnt), 256'(mon_e.gnt));
            chk("load_rs", 256'(load_rs), 256'(mon_e.gnt));
            if (mon_e.gnt) chk("alloc_tag", 256'(alloc_tag), 256'(mon_e.tag));
            chk("commit_valid", 256'(commit_valid), 256'(mon_e.cv));
            chk("num_available", 256'(num_available), 256'(mon_e.navail));
            chk("rob_rdy", 256'(rob_rdy), 256'(mon_e.rdy));
            chk("rob_data", rob_data, mon_e.data);
            if (commit_valid === 1'b1) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL commit_unexpected: got tag %0h none expected at %0t", commit_tag, $time);
                end else begin
                    mon_c = cq.pop_front();
                    chk("commit_rd", 256'(commit_rd), 256'(mon_c.rd));
                    chk("commit_data", 256'(commit_data), 256'(mon_c.data));
                    chk("commit_tag", 256'(commit_tag), 256'(mon_c.tag));
                end
            end
        end
    end

    initial begin
        // Reset, then reset again mid-operation with three live entries.
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        rst = 1'b0;
        step(1'b1, 5'd5, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        step(1'b1, 5'd5, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        rst = 1'b1;
        alloc(5'd7);
        do_flush();

        // Fill to full, refuse the ninth, retire tag 0, then wrap to tag 0.
        for (int i = 0; i < SIZE; i++) alloc(5'(i + 1));
        step(1'b1, 5'd9, 1'b0, 2'b01, 4'd0, 4'd0, 32'h100, 32'h0);
        step(1'b1, 5'd9, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        alloc(5'd10);
        do_flush();

        // Out-of-order completion, in-order retirement.
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        wr(4'd2, 32'hCAFE); wr(4'd0, 32'h11); wr(4'd1, 32'h22);
        repeat (4) idle();

        // Dual-bus collision on tag 3; write to unallocated tag 5.
        alloc(5'd4); alloc(5'd5);
        step(1'b0, 5'd0, 1'b0, 2'b11, 4'd3, 4'd3, 32'hAAAA, 32'hBBBB);
        wr(4'd5, 32'h55);
        repeat (2) idle();

        // Simultaneous allocate and retire at count 4.
        alloc(5'd6); alloc(5'd7); alloc(5'd8);
        wr(4'd4, 32'h44);
        alloc(5'd9);
        idle();

        // Flush with five live entries and a ready head.
        do_flush();
        for (int i = 0; i < 5; i++) alloc(5'(i + 11));
        wr(4'd0, 32'hF00D);
        do_flush();
        alloc(5'd20);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom), ($urandom_range(0, 63) == 0),
                 2'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 $urandom, $urandom);
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_queue_drain: got %0d left expected 0", exp_q.size());
        end
        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL commit_queue_drain: got %0d left expected 0", cq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
